// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : cpu_pkg                                                      |
// | Description: Shared fetch-path constants, FIFO entry type, fetch FSM     |
// |              state encoding and PC alignment helper.                      |
// | Revision   : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package cpu_pkg;

    localparam logic [31:0] RESET_PC          = 32'h0000_0000;
    localparam logic [31:0] NOP               = 32'h0000_0000;
    localparam logic [31:0] PC_RESET_SENTINEL = 32'hffff_fffc;

    // Occupancy counters are sized for the largest legal credit count (4).
    localparam int          CNT_W             = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : fetch_fifo                                                   |
// | Description: Small FIFO of {pc, instr} entries with push, pop, flush,    |
// |              occupancy count, empty and full. Depth 1..4.                 |
// | Revision   : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Pointer wrap for depths that are not a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Entry storage; contents need no reset because count gates their use.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; flush discards everything in one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : fetch_unit                                                   |
// | Description: Instruction-fetch front end. Owns the fetch PC, issues      |
// |              credit-limited word requests, buffers returned words and    |
// |              presents one instruction per cycle to IF/ID. Handles stall  |
// |              hold and branch/jump redirects (stall_j marks the bubble).   |
// | Options    : FETCH_PERF_EN adds perf_bubbles / perf_redirects counters.  |
// | Revision   : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [31:0] BUBBLE   = cpu_pkg::NOP,
    parameter int          CREDITS  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        stall_j
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_bubbles,
    output logic [31:0] perf_redirects
`endif
);

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] kill_q;
    logic [CNT_W-1:0] kill_d;

    fetch_entry_t     inflight_head;
    fetch_entry_t     fifo_head;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] fifo_count;
    logic             inflight_empty;
    logic             inflight_full;
    logic             fifo_empty;
    logic             fifo_full;

    logic             resp_live;
    logic             resp_kill;
    logic             fifo_push;
    logic             pop;
    logic [CNT_W-1:0] credit_used;
    logic             credit_ok;
    logic             unused_bits;

    // A response with nothing in flight is stray (e.g. from before a reset).
    assign resp_live   = imem_rvalid && !inflight_empty;
    assign resp_kill   = resp_live && (kill_q != '0);
    assign fifo_push   = resp_live && (kill_q == '0) && !redirect_valid;
    assign pop         = !redirect_valid && !stall && !fifo_empty;
    assign credit_used = outstanding + fifo_count - CNT_W'(pop);
    assign credit_ok   = (credit_used < CNT_W'(CREDITS)) && !redirect_valid;
    assign imem_addr   = pc_q;
    assign unused_bits = ^{inflight_head.instr, inflight_full, fifo_full};

    // In-flight address queue: one entry per issued request, retired per response.
    fetch_fifo #(.DEPTH(CREDITS)) u_inflight (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (imem_req),
        .pop   (resp_live),
        .flush (1'b0),
        .wdata ('{pc: pc_q, instr: 32'h0}),
        .rdata (inflight_head),
        .count (outstanding),
        .empty (inflight_empty),
        .full  (inflight_full)
    );

    // Returned-word buffer feeding the output register.
    fetch_fifo #(.DEPTH(CREDITS)) u_words (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ('{pc: inflight_head.pc, instr: imem_rdata}),
        .rdata (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Next state, kill counter and request strobe.
    always_comb begin
        state_d  = state_q;
        kill_d   = kill_q;
        imem_req = 1'b0;
        if (redirect_valid) begin
            kill_d = outstanding - CNT_W'(resp_live);
        end else if (resp_kill) begin
            kill_d = kill_q - 1'b1;
        end
        case (state_q)
            ST_RESET: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                imem_req = credit_ok;
                if (redirect_valid && (outstanding != '0)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                imem_req = credit_ok;
                if (redirect_valid) begin
                    state_d = (outstanding != '0) ? ST_DRAIN : ST_RUN;
                end else if (kill_d == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // FSM state, kill counter and fetch PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
            kill_q  <= '0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            if (redirect_valid) begin
                pc_q <= word_align(redirect_pc);
            end else if (imem_req) begin
                pc_q <= pc_q + 32'd4;
            end
        end
    end

    // IF/ID-facing register: redirect bubble first, otherwise advance unless stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_pc          <= PC_RESET_SENTINEL;
            if_instruction <= BUBBLE;
            stall_j        <= 1'b0;
        end else if (redirect_valid) begin
            if_instruction <= BUBBLE;
            stall_j        <= 1'b1;
        end else if (!stall) begin
            stall_j <= 1'b0;
            if (!fifo_empty) begin
                if_pc          <= fifo_head.pc;
                if_instruction <= fifo_head.instr;
            end else begin
                if_instruction <= BUBBLE;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating counts of starvation bubbles and redirect edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubbles   <= '0;
            perf_redirects <= '0;
        end else begin
            if (redirect_valid && (perf_redirects != '1)) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
            if (!redirect_valid && !stall && fifo_empty && (perf_bubbles != '1)) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage front end: owns the fetch PC, issues word requests to instruction memory, buffers returned words, and presents one instruction per cycle to the IF/ID pipeline register. It honours the downstream `stall` hold and branch/jump redirects, and emits `stall_j` to mark squash bubbles. It sits between instruction memory and IF/ID and drives IF/ID's `IF_PC`, `IF_instruction` and `stall_j` inputs.

## Interface

- `RESET_PC`, default 32'h0000_0000: address of the first fetch after reset.
- `BUBBLE`, default 32'h0000_0000: instruction word inserted as a bubble (NOP).
- `CREDITS`, default 2: maximum of outstanding requests plus buffered words. Legal values are 1..4.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `stall` in 1: IF/ID hold, from the load-use hazard logic.
- `redirect_valid` in 1: single-cycle branch/jump redirect.
- `redirect_pc` in 32: redirect target. Bits [1:0] are ignored and forced to 0.
- `imem_req` out 1: request strobe. Memory accepts the request every cycle.
- `imem_addr` out 32: word address of the request.
- `imem_rvalid` in 1: response valid. Responses return in order with a latency of at least 1 cycle.
- `imem_rdata` in 32: response word.
- `if_pc` out 32: PC of the presented instruction, registered.
- `if_instruction` out 32: presented instruction, registered.
- `stall_j` out 1: 1 when the presented word is a redirect bubble, registered.

## Operation

- **Fetch PC `pc_q`**
  - Reset value: `RESET_PC`.
  - Advances by 4 on each issued request, wrapping modulo 2^32.
  - Loads `redirect_pc & ~3` on a redirect edge.
- **Issue**
  - `imem_req = (outstanding + count - pop) < CREDITS && !redirect_valid`.
  - `imem_addr = pc_q`.
  - `pop` means a FIFO entry is consumed this cycle.
- **Response tracking**
  - Each issued address is pushed into an in-flight PC queue.
  - On `imem_rvalid`:
    - If `kill_cnt > 0`: decrement `kill_cnt` and drop the word.
    - Otherwise: push {in-flight PC, `imem_rdata`} into the fetch FIFO.
  - `imem_rvalid` with `outstanding == 0` is ignored.
- **Output register**, updated only on edges where `stall == 0`:
  - FIFO non-empty: load its head into `if_pc`/`if_instruction`, set `stall_j = 0`, and pop.
  - FIFO empty (starvation): load `BUBBLE`, keep `if_pc`, set `stall_j = 0`.
- **Redirect edge** (this has priority over everything else):
  - The fetch FIFO is flushed.
  - `kill_cnt` is set to `outstanding` minus any response arriving this cycle.
  - `pc_q` is loaded with the target.
  - The output register loads `BUBBLE` with `stall_j = 1`, regardless of `stall`. While `stall` is high, IF/ID ignores this value; it captures the bubble once `stall` falls.
- **FSM**
  - States: `RESET`, `RUN`, `DRAIN`.
  - `RESET` → `RUN` on the first clk after `rst_n` deassertion. No request is issued in `RESET`.
  - `RUN` → `DRAIN` on a redirect with `outstanding > 0`.
  - `DRAIN` → `RUN` when `kill_cnt` reaches 0. New requests may issue during `DRAIN`; their responses are accepted after the killed ones.
  - A redirect while in `DRAIN` re-arms `kill_cnt` as above.
- **Reset mid-operation**: state, FIFO, queues and counters clear asynchronously. Late memory responses after reset are ignored.

## Timing

- Reset values:
  - `if_pc` = 32'hffff_fffc.
  - `if_instruction` = `BUBBLE`.
  - `stall_j` = 0.
  - `imem_req` = 0.
- Latency: request in cycle t, response in t+1 (pushed at the end of t+1), visible on `if_instruction` after the edge ending t+2. Fetch-to-IF/ID latency is 2 cycles plus the memory latency beyond 1.
- Throughput: 1 instruction/cycle sustained with memory latency 1 and `CREDITS` ≥ 2.
- `stall` high for N cycles: outputs frozen for N edges. Issue stops once credits are exhausted, and no words are lost.
- Redirect: the first target instruction appears 3 edges after the redirect edge (memory latency 1). Exactly one `stall_j = 1` bubble precedes any starvation bubbles.

## Configuration

- `FETCH_PERF_EN` defined: adds two output ports, each saturating at all-ones:
  - `perf_bubbles` out 32: starvation bubbles presented.
  - `perf_redirects` out 32: redirect edges.
- `FETCH_PERF_EN` undefined: these ports and counters do not exist.

## Structure

- Shared package `cpu_pkg` holds `RESET_PC`, the `BUBBLE`/NOP constant, and the `PC_RESET_SENTINEL` value 32'hffff_fffc.
- One sub-module, `fetch_fifo`: a parameterised-depth FIFO of {pc, instr} with push, pop, flush, count, empty and full. It is instantiated once for returned words. The in-flight PC queue is a second instance with the data field tied off.

## Test plan

- Reset release, memory latency 1: `imem_addr` = 0, 4, 8, … on consecutive cycles; `if_instruction` matches the memory words from the third edge onward; `stall_j` stays 0.
- `stall` held 3 cycles mid-stream: `if_pc` is held at 0x10 for 3 edges, then continues at 0x14 with no gap or duplicate.
- Redirect to 0x200 with 2 outstanding requests: both late words are dropped; one bubble with `stall_j = 1`; then the PCs 0x200, 0x204 are presented.
- Redirect and `stall` in the same cycle: after `stall` falls, IF/ID sees a bubble with `stall_j = 1`, then 0x200.
- Memory latency 3: starvation bubbles appear with `stall_j = 0` and `if_pc` unchanged; instruction order is preserved.
- `rst_n` pulsed low with 2 requests outstanding: outputs go to their reset values; stray `imem_rvalid` is ignored; fetch restarts at `RESET_PC`.
